// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount22 family: vector/count types, generator FSM states,
// weight-class masks and a binomial helper.
package popcount_pkg;

    localparam int unsigned N_IN = 22;
    localparam int unsigned KW   = $clog2(N_IN + 1);
    localparam int unsigned CW   = 20;

    typedef logic [N_IN-1:0] pc_vec_t;
    typedef logic [KW-1:0]   pc_cnt_t;
    typedef logic [CW-1:0]   pc_idx_t;

    localparam pc_cnt_t N_CNT = pc_cnt_t'(N_IN);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StErr
    } gen_state_e;

    // Lowest vector of weight k: k ones packed at the bottom. Valid for k <= N_IN.
    function automatic pc_vec_t low_mask(input pc_cnt_t k);
        logic [N_IN:0] ext;
        ext = ((N_IN + 1)'(1) << k) - (N_IN + 1)'(1);
        return pc_vec_t'(ext);
    endfunction

    // Highest vector of weight k: k ones packed at the top.
    function automatic pc_vec_t top_mask(input pc_cnt_t k);
        return low_mask(k) << (N_CNT - k);
    endfunction

    function automatic longint unsigned binom(input int unsigned n, input int unsigned k);
        longint unsigned r;
        r = 1;
        if (k > n) return 0;
        for (int unsigned i = 0; i < k; i++) begin
            r = r * longint'(n - i) / longint'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount_gosper_succ.sv
// Combinational Gosper successor: next larger vector with the same Hamming weight.
// Uses a trailing-zero priority encoder in place of the divide by the lowest set bit.
module popcount_gosper_succ
    import popcount_pkg::*;
(
    input  logic [N_IN-1:0] v,
    output logic [N_IN-1:0] next
);

    logic [KW-1:0]   tz;
    logic [N_IN:0]   ve;
    logic [N_IN:0]   c;
    logic [N_IN:0]   r;
    logic [N_IN-1:0] s;

    always_comb begin
        tz = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) tz = KW'(i);
        end
    end

    // One extra bit so the carry out of v + lowbit survives into r ^ v.
    assign ve   = {1'b0, v};
    assign c    = ve & (~ve + (N_IN + 1)'(1));
    assign r    = ve + c;
    assign s    = N_IN'(((r ^ ve) >> 2) >> tz);
    assign next = r[N_IN-1:0] | s;

endmodule

// File: rtl/popcount22_weight_gen.sv
// Streams every 22-bit vector of a commanded Hamming weight in ascending order, one per beat,
// with a valid/ready output handshake and an error pulse for out-of-range weights.
module popcount22_weight_gen
    import popcount_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [KW-1:0]   cmd_weight,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_IN-1:0] out_vec,
    output logic [CW-1:0]   out_idx,
    output logic            out_last,
    output logic            err
);

    gen_state_e state;
    pc_cnt_t    weight;
    pc_vec_t    succ_vec;
    logic       succ_is_last;
    logic       beat_taken;
    logic       cmd_accept;

    popcount_gosper_succ u_succ (
        .v    (out_vec),
        .next (succ_vec)
    );

    assign succ_is_last = (succ_vec == top_mask(weight));
    assign beat_taken   = out_valid && out_ready;
    assign cmd_accept   = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            weight    <= '0;
            cmd_ready <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_accept) begin
                        if (cmd_weight > N_CNT) begin
                            state     <= StErr;
                            err       <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else begin
                            state     <= StStream;
                            weight    <= cmd_weight;
                            cmd_ready <= 1'b0;
                            out_valid <= 1'b1;
                            out_vec   <= low_mask(cmd_weight);
                            out_idx   <= '0;
                            // Weights 0 and N have a single member, so the first beat is the last.
                            out_last  <= (cmd_weight == '0) || (cmd_weight == N_CNT);
                        end
                    end
                end
                StErr: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                end
                StStream: begin
                    if (beat_taken) begin
                        if (out_last) begin
                            state     <= StIdle;
                            cmd_ready <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_vec  <= succ_vec;
                            out_idx  <= out_idx + CW'(1);
                            out_last <= succ_is_last;
                        end
                    end
                end
                default: begin
                    state     <= StIdle;
                    cmd_ready <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    a_hold_when_stalled: assert property (
        @(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(out_vec) && $stable(out_idx)
                                    && $stable(out_last)
    );

    a_weight_matches: assert property (
        @(posedge clk) disable iff (rst)
        out_valid |-> $countones(out_vec) == int'(weight)
    );

endmodule
